// File: rtl/adj_key_ctrl.sv
// rtl/adj_key_ctrl.sv - debounced four-key run/set FSM driving digit select, add/clr pulses and blink
// Define ADJ_TIMEOUT_EN to return to run mode after TIMEOUT_CYC idle cycles in set mode.
module adj_key_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int PULSE_CYC    = 4,
  parameter int TIMEOUT_CYC  = 500_000_000,
  parameter int BLINK_CYC    = 12_500_000
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_next,
  input  logic       key_add,
  input  logic       key_clr,
  output logic       adjust,
  output logic [3:0] select,
  output logic       add,
  output logic       clr,
  output logic       blink
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int PL_W = $clog2(PULSE_CYC + 1);
  localparam int BL_W = $clog2(BLINK_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PL_W-1:0] PL_LAST = PL_W'(PULSE_CYC - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYC - 1);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] SET_IDLE = 2'd1;
  localparam logic [1:0] SET_ADD  = 2'd2;
  localparam logic [1:0] SET_CLR  = 2'd3;

  if (DEBOUNCE_CYC < 1 || PULSE_CYC < 1 || TIMEOUT_CYC < 1 || BLINK_CYC < 1) begin : g_bad_param
    $error("adj_key_ctrl: all cycle parameters must be at least 1");
  end

  // key bit order: [3] mode, [2] next, [1] add, [0] clr
  logic [3:0]      key_raw;
  logic [3:0]      sync_q1;
  logic [3:0]      sync_q2;
  logic [3:0]      deb_lvl;
  logic [3:0]      armed;
  logic [3:0]      differ;
  logic [3:0]      settled;
  logic [3:0]      key_ev;
  logic [DB_W-1:0] db_cnt [4];

  logic            ev_mode;
  logic            ev_next;
  logic            ev_add;
  logic            ev_clr;
  logic            ev_any;
  logic            timeout;

  logic [1:0]      state;
  logic [PL_W-1:0] pulse_cnt;
  logic [BL_W-1:0] blink_cnt;

  assign key_raw = {key_mode, key_next, key_add, key_clr};

  // Synchronizers reset high so a key held through reset reads as pressed until seen released.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 4'hF;
      sync_q2 <= 4'hF;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  // An unarmed key first has to be debounced low before any rising edge counts.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      differ[i]  = sync_q2[i] != (armed[i] ? deb_lvl[i] : 1'b1);
      settled[i] = differ[i] && (db_cnt[i] == DB_LAST);
      key_ev[i]  = armed[i] && settled[i] && sync_q2[i];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      deb_lvl <= '0;
      armed   <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!differ[i]) begin
          db_cnt[i] <= '0;
        end else if (settled[i]) begin
          db_cnt[i] <= '0;
          if (armed[i]) begin
            deb_lvl[i] <= sync_q2[i];
          end else begin
            armed[i] <= 1'b1;
          end
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign ev_mode = key_ev[3];
  assign ev_next = key_ev[2];
  assign ev_add  = key_ev[1];
  assign ev_clr  = key_ev[0];
  assign ev_any  = |key_ev;

`ifdef ADJ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state != SET_IDLE || ev_any) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TO_LAST) begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  assign timeout = (state == SET_IDLE) && !ev_any && (idle_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  // add/clr come straight from flops: the time datapath clocks on them.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      adjust    <= 1'b1;
      select    <= 4'd0;
      add       <= 1'b0;
      clr       <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ev_mode) begin
            state  <= SET_IDLE;
            adjust <= 1'b0;
          end
        end
        SET_IDLE: begin
          if (ev_mode || timeout) begin
            state  <= RUN;
            adjust <= 1'b1;
          end else if (ev_clr) begin
            state     <= SET_CLR;
            clr       <= 1'b1;
            pulse_cnt <= '0;
          end else if (ev_add) begin
            state     <= SET_ADD;
            add       <= 1'b1;
            pulse_cnt <= '0;
          end else if (ev_next) begin
            select <= select + 4'd1;
          end
        end
        SET_ADD, SET_CLR: begin
          if (pulse_cnt == PL_LAST) begin
            state     <= SET_IDLE;
            add       <= 1'b0;
            clr       <= 1'b0;
            pulse_cnt <= '0;
          end else begin
            pulse_cnt <= pulse_cnt + PL_W'(1);
          end
        end
        default: begin
          state  <= RUN;
          adjust <= 1'b1;
          add    <= 1'b0;
          clr    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (state == RUN) begin
      blink     <= ev_mode;
      blink_cnt <= '0;
    end else if (state == SET_IDLE && (ev_mode || timeout)) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (blink_cnt == BL_LAST) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BL_W'(1);
    end
  end

endmodule

// File: tb/tb_adj_key_ctrl.sv
// tb/tb_adj_key_ctrl.sv - table-driven bench for adj_key_ctrl with small cycle parameters
module tb_adj_key_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n    = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_next = 1'b0;
  logic       key_add  = 1'b0;
  logic       key_clr  = 1'b0;
  logic       adjust;
  logic [3:0] select;
  logic       add;
  logic       clr;
  logic       blink;

  int checks = 0;
  int errors = 0;

  int         add_cyc;
  int         clr_cyc;
  int         add_rise;
  int         overlap = 0;
  int         sel_moves = 0;
  int         adj_moves = 0;
  logic [3:0] sel_prev;
  logic       adj_prev;
  logic       add_prev;

  typedef struct {
    string      name;
    logic [3:0] keys;
    int         hold;
    int         gap;
    int         exp_adjust;
    int         exp_select;
    int         exp_add;
    int         exp_clr;
  } vec_t;

  vec_t vecs[$];

  always #10 CLOCK_50 = ~CLOCK_50;

  adj_key_ctrl #(
    .DEBOUNCE_CYC(4),
    .PULSE_CYC   (3),
    .TIMEOUT_CYC (50),
    .BLINK_CYC   (8)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .rst_n   (rst_n),
    .key_mode(key_mode),
    .key_next(key_next),
    .key_add (key_add),
    .key_clr (key_clr),
    .adjust  (adjust),
    .select  (select),
    .add     (add),
    .clr     (clr),
    .blink   (blink)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key_mode, key_next, key_add, key_clr} = k;
  endtask

  task automatic clear_counts();
    add_cyc  = 0;
    clr_cyc  = 0;
    add_rise = 0;
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    if (add) add_cyc++;
    if (clr) clr_cyc++;
    if (add && !add_prev) add_rise++;
    if (add && clr) overlap++;
    if ((add || clr) && select != sel_prev) sel_moves++;
    if ((add || clr) && adjust != adj_prev) adj_moves++;
    sel_prev = select;
    adj_prev = adjust;
    add_prev = add;
  endtask

  task automatic apply_vec(input vec_t v);
    clear_counts();
    set_keys(v.keys);
    repeat (v.hold) tick();
    set_keys(4'b0000);
    repeat (v.gap) tick();
    check({v.name, ".adjust"}, adjust, v.exp_adjust);
    check({v.name, ".select"}, select, v.exp_select);
    check({v.name, ".add_cycles"}, add_cyc, v.exp_add);
    check({v.name, ".clr_cycles"}, clr_cyc, v.exp_clr);
  endtask

  task automatic add_vec(input string name, input logic [3:0] keys, input int exp_adjust,
                         input int exp_select, input int exp_add, input int exp_clr);
    vec_t v;
    v.name = name;
    v.keys = keys;
    v.hold = 10;
    v.gap = 10;
    v.exp_adjust = exp_adjust;
    v.exp_select = exp_select;
    v.exp_add = exp_add;
    v.exp_clr = exp_clr;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  found;

    // keys: {mode, next, add, clr}
    for (int i = 0; i < 17; i++) add_vec($sformatf("next_%0d", i), 4'b0100, 0, (i + 1) % 16, 0, 0);
    for (int i = 0; i < 5; i++) add_vec($sformatf("next_to6_%0d", i), 4'b0100, 0, 2 + i, 0, 0);
    add_vec("add_sel6",      4'b0010, 0, 6, 3, 0);
    add_vec("clr_sel6",      4'b0001, 0, 6, 0, 3);
    add_vec("add_clr_same",  4'b0011, 0, 6, 0, 3);
    add_vec("next_add_same", 4'b0110, 0, 6, 3, 0);
    add_vec("mode_to_run",   4'b1000, 1, 6, 0, 0);
    add_vec("run_next",      4'b0100, 1, 6, 0, 0);
    add_vec("run_add",       4'b0010, 1, 6, 0, 0);
    add_vec("run_clr",       4'b0001, 1, 6, 0, 0);
    add_vec("mode_to_set",   4'b1000, 0, 6, 0, 0);
    add_vec("mode_clr_same", 4'b1001, 1, 6, 0, 0);
    add_vec("run_mode_add",  4'b1010, 0, 6, 0, 0);
    add_vec("all_keys_set",  4'b1111, 1, 6, 0, 0);

    clear_counts();
    sel_prev = 4'd0;
    adj_prev = 1'b1;
    add_prev = 1'b0;
    repeat (2) tick();
    check("reset.adjust", adjust, 1);
    check("reset.select", select, 0);
    check("reset.add", add, 0);
    check("reset.clr", clr, 0);
    check("reset.blink", blink, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    check("idle_run.adjust", adjust, 1);

    // enter set mode and follow the first blink half-period
    set_keys(4'b1000);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (!adjust) found = 1;
    end
    check("enter_set.found", found, 1);
    check("enter_set.blink", blink, 1);
    check("enter_set.select", select, 0);
    repeat (7) tick();
    check("blink.hold_7", blink, 1);
    tick();
    check("blink.toggle_8", blink, 0);
    set_keys(4'b0000);
    repeat (6) tick();

    // 2-cycle glitches on key_mode must never debounce
    for (int i = 0; i < 3; i++) begin
      set_keys(4'b1000);
      repeat (2) tick();
      set_keys(4'b0000);
      repeat (2) tick();
    end
    repeat (6) tick();
    check("glitch.adjust", adjust, 0);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // clr lands while the add pulse is running and must be dropped
    apply_vec('{"mode_for_drop", 4'b1000, 10, 10, 0, 6, 0, 0});
    clear_counts();
    set_keys(4'b0010);
    repeat (2) tick();
    set_keys(4'b0011);
    repeat (12) tick();
    set_keys(4'b0000);
    repeat (10) tick();
    check("drop.add_cycles", add_cyc, 3);
    check("drop.add_pulses", add_rise, 1);
    check("drop.clr_cycles", clr_cyc, 0);
    check("drop.select", select, 6);

    // reset in the middle of an add pulse with key_add held through release
    set_keys(4'b0010);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (add) found = 1;
    end
    check("rst_mid.pulse_seen", found, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.add", add, 0);
    check("rst_mid.adjust", adjust, 1);
    check("rst_mid.select", select, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    clear_counts();
    repeat (20) tick();
    check("held_add.add_cycles", add_cyc, 0);
    check("held_add.adjust", adjust, 1);
    set_keys(4'b0000);
    repeat (12) tick();
    apply_vec('{"post_rst_mode", 4'b1000, 10, 10, 0, 0, 0, 0});
    apply_vec('{"post_rst_add", 4'b0010, 10, 10, 0, 0, 3, 0});
    apply_vec('{"exit_for_to", 4'b1000, 10, 10, 1, 0, 0, 0});

    // idle timeout behaviour in set mode
    set_keys(4'b1000);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (!adjust) found = 1;
    end
    check("to_enter.found", found, 1);
    n = 0;
    found = 0;
    for (int i = 1; i <= 200 && !found; i++) begin
      tick();
      if (i == 4) set_keys(4'b0000);
      if (adjust) begin
        found = 1;
        n = i;
      end
    end
`ifdef ADJ_TIMEOUT_EN
    check("timeout.fired", found, 1);
    check("timeout.cycle", n, 50);
    check("timeout.select", select, 0);
    check("timeout.blink", blink, 0);
`else
    check("no_timeout.adjust", adjust, 0);
    check("no_timeout.fired", found, 0);
`endif

    check("add_clr_overlap", overlap, 0);
    check("select_moved_in_pulse", sel_moves, 0);
    check("adjust_moved_in_pulse", adj_moves, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
